// File: rtl/clken_ramp_sequencer_if.sv
// Signal bundle between the fsl_clk control sources and the clock-enable ramp sequencer.
// Optional macro CLKEN_SEQ_ACTIVE_COUNT_EN adds the active_count return signal.
interface clken_ramp_sequencer_if #(
    parameter int NUM_REGIONS = 29
);
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic                   fsl_rst;
    logic                   stop;
    logic                   kill;
    logic [NUM_REGIONS-1:0] region_mask;
    logic [NUM_REGIONS-1:0] clken;
    logic [1:0]             state;
    logic                   all_on;
    logic                   ramp_done;
    logic                   off_done;
`ifdef CLKEN_SEQ_ACTIVE_COUNT_EN
    logic [IDX_W:0]         active_count;

    modport master (
        output fsl_rst, stop, kill, region_mask,
        input  clken, state, all_on, ramp_done, off_done, active_count
    );
    modport slave (
        input  fsl_rst, stop, kill, region_mask,
        output clken, state, all_on, ramp_done, off_done, active_count
    );
`else
    modport master (
        output fsl_rst, stop, kill, region_mask,
        input  clken, state, all_on, ramp_done, off_done
    );
    modport slave (
        input  fsl_rst, stop, kill, region_mask,
        output clken, state, all_on, ramp_done, off_done
    );
`endif
endinterface

// File: rtl/clken_ramp_sequencer.sv
// Staggered soft-start / soft-stop of per-region clock enables in the fsl_clk domain.
// Optional macro CLKEN_SEQ_ACTIVE_COUNT_EN adds a registered popcount of clken.
module clken_ramp_sequencer #(
    parameter int NUM_REGIONS = 29,
    parameter int STEP_LOG2   = 18
) (
    input logic                   clk,
    input logic                   rst,
    clken_ramp_sequencer_if.slave sif
);
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_REGIONS - 1);
    localparam logic [STEP_LOG2-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [STEP_LOG2-1:0]   cnt_q, cnt_d;
    logic [NUM_REGIONS-1:0] ce_q, ce_d;
    logic [NUM_REGIONS-1:0] clken_q, clken_d;
    logic                   armed_q, armed_d;
    logic                   fsl_rst_dly_q;
    logic                   ramp_done_q, ramp_done_d;
    logic                   off_done_q, off_done_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ce_d        = ce_q;
        armed_d     = armed_q;
        ramp_done_d = 1'b0;
        off_done_d  = 1'b0;

        if (!sif.fsl_rst && fsl_rst_dly_q) begin
            armed_d = 1'b1;
        end

        if (sif.fsl_rst) begin
            armed_d = 1'b0;
            ce_d    = '0;
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (sif.kill) begin
            // Hard stop keeps the arm so the ramp restarts once kill clears.
            ce_d    = '0;
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (armed_q && !sif.stop) begin
                        state_d = RAMP_UP;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
                RAMP_UP: begin
                    if (sif.stop) begin
                        state_d = RAMP_DOWN;
                        cnt_d   = '0;
                    end else begin
                        ce_d[idx_q] = 1'b1;
                        cnt_d       = cnt_q + STEP_LOG2'(1);
                        if (cnt_q == CNT_MAX) begin
                            if (idx_q == LAST_IDX) begin
                                state_d     = RUN;
                                ramp_done_d = 1'b1;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end
                    end
                end
                RUN: begin
                    ce_d = '1;
                    if (sif.stop) begin
                        state_d = RAMP_DOWN;
                        idx_d   = LAST_IDX;
                        cnt_d   = '0;
                    end
                end
                RAMP_DOWN: begin
                    // Runs to completion regardless of stop; only kill/fsl_rst cut it short.
                    ce_d[idx_q] = 1'b0;
                    cnt_d       = cnt_q + STEP_LOG2'(1);
                    if (cnt_q == CNT_MAX) begin
                        if (idx_q == '0) begin
                            state_d    = IDLE;
                            armed_d    = 1'b0;
                            off_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q - IDX_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        clken_d = ce_q & sif.region_mask & ~{NUM_REGIONS{sif.kill}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            ce_q          <= '0;
            clken_q       <= '0;
            armed_q       <= 1'b0;
            fsl_rst_dly_q <= 1'b0;
            ramp_done_q   <= 1'b0;
            off_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            ce_q          <= ce_d;
            clken_q       <= clken_d;
            armed_q       <= armed_d;
            fsl_rst_dly_q <= sif.fsl_rst;
            ramp_done_q   <= ramp_done_d;
            off_done_q    <= off_done_d;
        end
    end

    assign sif.clken     = clken_q;
    assign sif.state     = state_q;
    assign sif.all_on    = (state_q == RUN);
    assign sif.ramp_done = ramp_done_q;
    assign sif.off_done  = off_done_q;

`ifdef CLKEN_SEQ_ACTIVE_COUNT_EN
    logic [IDX_W:0] active_count_q;

    function automatic logic [IDX_W:0] popcount(input logic [NUM_REGIONS-1:0] v);
        logic [IDX_W:0] sum;
        sum = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            sum = sum + (IDX_W + 1)'(v[k]);
        end
        return sum;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            active_count_q <= '0;
        end else begin
            active_count_q <= popcount(clken_q);
        end
    end

    assign sif.active_count = active_count_q;
`endif
endmodule

// File: tb/tb_clken_ramp_sequencer.sv
// Scoreboard bench for clken_ramp_sequencer with NUM_REGIONS=4, STEP_LOG2=2.
module tb_clken_ramp_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clken_ramp_sequencer_if #(.NUM_REGIONS(4)) sif ();
    clken_ramp_sequencer #(.NUM_REGIONS(4), .STEP_LOG2(2)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    typedef struct {
        int         cyc;
        logic [3:0] clken;
        logic [1:0] state;
        logic       rd;
        logic       od;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compares every queued expectation on its cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL sb_late actual_cyc=%0d required_cyc=%0d", cyc, e.cyc);
                end else begin
                    if (sif.clken !== e.clken) begin
                        n_fail++;
                        $display("FAIL sb_clken cyc=%0d actual=%b required=%b", cyc, sif.clken, e.clken);
                    end
                    n_tests++;
                    if (sif.state !== e.state) begin
                        n_fail++;
                        $display("FAIL sb_state cyc=%0d actual=%0d required=%0d", cyc, sif.state, e.state);
                    end
                    n_tests++;
                    if (sif.ramp_done !== e.rd) begin
                        n_fail++;
                        $display("FAIL sb_ramp_done cyc=%0d actual=%b required=%b", cyc, sif.ramp_done, e.rd);
                    end
                    n_tests++;
                    if (sif.off_done !== e.od) begin
                        n_fail++;
                        $display("FAIL sb_off_done cyc=%0d actual=%b required=%b", cyc, sif.off_done, e.od);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected ramp-up timeline from entry cycle e: clken[k] rises at e+2+4k, RUN at e+16.
    task automatic push_up(input int e, input logic [3:0] m, input int from, input int to);
        for (int c = from; c <= to; c++) begin
            exp_t x;
            x.cyc = c;
            for (int k = 0; k < 4; k++) x.clken[k] = (c >= e + 2 + 4 * k) && m[k];
            x.state = (c >= e + 16) ? 2'd2 : 2'd1;
            x.rd    = (c == e + 16);
            x.od    = 1'b0;
            sb.push_back(x);
        end
    endtask

    // Expected ramp-down from stop sampled at d: clken[k] falls at d+3+4*(3-k), IDLE at d+17.
    task automatic push_down(input int d, input logic [3:0] m, input int from, input int to);
        for (int c = from; c <= to; c++) begin
            exp_t x;
            x.cyc = c;
            for (int k = 0; k < 4; k++) x.clken[k] = (c < d + 3 + 4 * (3 - k)) && m[k];
            x.state = (c <= d) ? 2'd2 : ((c < d + 17) ? 2'd3 : 2'd0);
            x.rd    = 1'b0;
            x.od    = (c == d + 17);
            sb.push_back(x);
        end
    endtask

    task automatic push_const(input int from, input int to, input logic [3:0] ck, input logic [1:0] st);
        for (int c = from; c <= to; c++) begin
            exp_t x;
            x.cyc   = c;
            x.clken = ck;
            x.state = st;
            x.rd    = 1'b0;
            x.od    = 1'b0;
            sb.push_back(x);
        end
    endtask

    task automatic wait_sb(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain_timeout actual_left=%0d required_left=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            tick();
            if (sif.state === s) at = cyc;
        end
    endtask

    task automatic arm_wait(output int e);
        sif.fsl_rst = 1'b1;
        repeat (5) tick();
        sif.fsl_rst = 1'b0;
        wait_state(2'd1, 10, e);
        n_tests++;
        if (e < 0) begin
            n_fail++;
            $display("FAIL ramp_up_entry timeout actual=%0d required=1", sif.state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_tests += 5;
        if (sif.clken !== 4'h0) begin n_fail++; $display("FAIL rst_clken actual=%b required=0000", sif.clken); end
        if (sif.state !== 2'd0) begin n_fail++; $display("FAIL rst_state actual=%0d required=0", sif.state); end
        if (sif.all_on !== 1'b0) begin n_fail++; $display("FAIL rst_all_on actual=%b required=0", sif.all_on); end
        if (sif.ramp_done !== 1'b0) begin n_fail++; $display("FAIL rst_ramp_done actual=%b required=0", sif.ramp_done); end
        if (sif.off_done !== 1'b0) begin n_fail++; $display("FAIL rst_off_done actual=%b required=0", sif.off_done); end
        rst = 1'b0;
        push_const(cyc + 1, cyc + 100, 4'h0, 2'd0);
        wait_sb(150);
    endtask

    task automatic test_ramp_up(input logic [3:0] m);
        int e;
        arm_wait(e);
        if (e < 0) return;
        n_tests++;
        if (sif.clken !== 4'h0) begin n_fail++; $display("FAIL up_entry_clken actual=%b required=0000", sif.clken); end
        push_up(e, m, e + 1, e + 17);
        wait_sb(40);
        n_tests++;
        if (sif.all_on !== 1'b1) begin n_fail++; $display("FAIL up_all_on actual=%b required=1", sif.all_on); end
    endtask

    task automatic test_ramp_down(input logic [3:0] m);
        int d;
        d = cyc;
        sif.stop = 1'b1;
        push_down(d, m, d + 1, d + 20);
        wait_sb(40);
        sif.stop = 1'b0;
        push_const(cyc + 1, cyc + 20, 4'h0, 2'd0);
        wait_sb(40);
    endtask

    task automatic test_kill();
        int e, k, e2;
        arm_wait(e);
        if (e < 0) return;
        while (cyc < e + 6) tick();
        n_tests++;
        if (sif.clken !== 4'b0011) begin n_fail++; $display("FAIL kill_pre_clken actual=%b required=0011", sif.clken); end
        k = cyc;
        sif.kill = 1'b1;
        tick();
        n_tests += 2;
        if (sif.clken !== 4'h0) begin n_fail++; $display("FAIL kill_clken actual=%b required=0000", sif.clken); end
        if (sif.state !== 2'd0) begin n_fail++; $display("FAIL kill_state actual=%0d required=0", sif.state); end
        sif.kill = 1'b0;
        wait_state(2'd1, 10, e2);
        n_tests++;
        if (e2 != k + 2) begin n_fail++; $display("FAIL kill_restart_cyc actual=%0d required=%0d", e2, k + 2); end
        if (e2 < 0) return;
        push_up(e2, 4'hF, e2 + 1, e2 + 17);
        wait_sb(40);
    endtask

    task automatic test_mask_change();
        int c;
        c = cyc;
        sif.region_mask = 4'b0110;
        push_const(c + 1, c + 3, 4'b0110, 2'd2);
        wait_sb(10);
`ifdef CLKEN_SEQ_ACTIVE_COUNT_EN
        sif.region_mask = 4'b1011;
        tick();
        tick();
        n_tests++;
        if (sif.active_count !== 3'd3) begin n_fail++; $display("FAIL active_count actual=%0d required=3", sif.active_count); end
`endif
    endtask

    task automatic test_fsl_rst_mid();
        int e, f, e2;
        sif.region_mask = 4'hF;
        sif.kill = 1'b1;
        tick();
        sif.kill = 1'b0;
        wait_state(2'd1, 10, e);
        n_tests++;
        if (e < 0) begin n_fail++; $display("FAIL mid_restart timeout actual=%0d required=1", sif.state); return; end
        while (cyc < e + 6) tick();
        f = cyc;
        sif.fsl_rst = 1'b1;
        tick();
        n_tests++;
        if (sif.state !== 2'd0) begin n_fail++; $display("FAIL fslrst_state actual=%0d required=0", sif.state); end
        push_const(f + 2, f + 12, 4'h0, 2'd0);
        wait_sb(20);
        sif.fsl_rst = 1'b0;
        wait_state(2'd1, 5, e2);
        n_tests++;
        if (e2 < 0) begin n_fail++; $display("FAIL fslrst_rearm actual=%0d required=1", sif.state); end
    endtask

    initial begin
        rst             = 1'b1;
        sif.fsl_rst     = 1'b0;
        sif.stop        = 1'b0;
        sif.kill        = 1'b0;
        sif.region_mask = 4'hF;
        test_reset();
        test_ramp_up(4'hF);
        test_ramp_down(4'hF);
        test_kill();
        test_ramp_down(4'hF);
        sif.region_mask = 4'b1010;
        test_ramp_up(4'b1010);
        test_mask_change();
        test_fsl_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clken_ramp_sequencer.md
Name: clken_ramp_sequencer

Overview:
- Parametrised successor to the top-level staggered clock-enable ramp for DES regions.
- Brings per-region clock enables up one slot at a time, soft-start.
- Adds a graceful staggered ramp-down in reverse order, an immediate kill, a per-region enable mask, state/status outputs, and arm-on-falling-edge of fsl_rst.
- Sits in the fsl_clk domain between fsl_rst / fsl_to_stream stop_clock and the clken inputs of the region array.

Parameters:
- NUM_REGIONS, 29, number of clken outputs (1..64).
- STEP_LOG2, 18, log2 of cycles per ramp slot (1..24).
- IDX_W (localparam), $clog2(NUM_REGIONS) min 1, region index width.

Ports:
- clk  in  1  fsl_clk domain clock.
- rst  in  1  synchronous, active-high reset.
- fsl_rst  in  1  chain reset; high = force off and disarm; falling edge arms.
- stop  in  1  level; request graceful ramp-down.
- kill  in  1  level; immediate all-off (stop_clock); does not disarm.
- region_mask  in  NUM_REGIONS  1 = region may be enabled.
- clken  out  NUM_REGIONS  registered clock enables.
- state  out  2  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3.
- all_on  out  1  state==RUN.
- ramp_done  out  1  one-cycle pulse on entry to RUN.
- off_done  out  1  one-cycle pulse when graceful ramp-down completes.

Behaviour:
- Reset values: clken=0, state=IDLE, all_on=0, ramp_done=0, off_done=0. Internals after reset: armed=0, ce=0, idx=0, cnt=0, fsl_rst_d=0.
- Priority each cycle: rst > fsl_rst > kill > stop.
- fsl_rst_d <= fsl_rst every cycle.
- fsl_rst==1: armed<=0, ce<=0, state<=IDLE.
- fsl_rst==0 && fsl_rst_d==1: armed<=1.
- kill==1 (any state): ce<=0, state<=IDLE, idx/cnt<=0, armed unchanged. Auto-restart once kill drops while armed.
- clken <= ce & region_mask & ~{kill}. clken lags ce by one register. kill forces clken=0 on the cycle after kill is sampled.
- IDLE: if armed & !stop & !kill, go to RAMP_UP with idx=0, cnt=0.
- RAMP_UP, each cycle:
  - ce[idx]<=1; cnt<=cnt+1, wrapping at 2^STEP_LOG2.
  - On cnt==max: if idx==NUM_REGIONS-1, go to RUN and pulse ramp_done; else idx<=idx+1.
- Timing from RAMP_UP entry cycle E: clken[k] rises at E+2+k*2^STEP_LOG2; state=RUN at E+NUM_REGIONS*2^STEP_LOG2.
- Masked regions still consume their slot; their clken stays 0. A mask change takes effect on clken the next cycle.
- RUN: ce all ones. stop==1 -> RAMP_DOWN with idx=NUM_REGIONS-1, cnt=0.
- stop during RAMP_UP: enter RAMP_DOWN at the current idx, cnt=0.
- RAMP_DOWN, each cycle:
  - ce[idx]<=0; cnt counts as in RAMP_UP.
  - On cnt==max: if idx==0, go to IDLE, armed<=0, pulse off_done; else idx<=idx-1.
- RAMP_DOWN never reverses: dropping stop does not abort it. Re-arm requires a fresh fsl_rst pulse.
- Entry into RAMP_DOWN from RUN at cycle D+1 (stop sampled at D): clken[k] falls at D+3+(NUM_REGIONS-1-k)*2^STEP_LOG2; IDLE at D+1+NUM_REGIONS*2^STEP_LOG2.
- cnt is STEP_LOG2 bits; idx is IDX_W bits, never exceeds NUM_REGIONS-1.

Optional Feature:
- Macro CLKEN_SEQ_ACTIVE_COUNT_EN.
- Defined: adds output active_count [IDX_W:0] = registered popcount of clken, lagging clken by one cycle, reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
All scenarios use NUM_REGIONS=4, STEP_LOG2=2, mask=4'hF unless stated.
- Power-up: rst 1->0, no fsl_rst pulse, 100 cycles -> clken=0, state=0 throughout.
- fsl_rst high 5 cycles, then low, ramp-up entered at E -> clken 0001@E+2, 0011@E+6, 0111@E+10, 1111@E+14; state=2 and ramp_done pulse at E+16.
- In RUN, stop asserted at D -> clken 0111@D+3, 0011@D+7, 0001@D+11, 0000@D+15; IDLE and off_done at D+17. Dropping stop afterwards gives no restart.
- kill pulsed 1 cycle at clken=0011 -> clken=0000 next cycle. After kill drops the ramp restarts from region 0: 0001 two cycles after re-entering RAMP_UP.
- mask=4'b1010, full ramp -> clken 0000, 0010, 0010, 1010 at the slot boundaries; RUN timing unchanged.
- With CLKEN_SEQ_ACTIVE_COUNT_EN, in RUN with mask 1011 -> active_count=3; fsl_rst asserted mid-ramp -> clken=0 within 2 cycles, state=IDLE, no restart until fsl_rst falls.
